branch_flag_unit: RTL and testbench
===================================

Name: branch_flag_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural flag register written from the ALU's 4-bit flag vector and returns the registered carry to the ALU as its carry input.
- Resolves conditional branch requests from decode against the current flags, with same-cycle bypass.
- Drives PC load and pipeline flush.
- Sits between execute (flag producer) and fetch/decode (branch consumer).

Parameters:
- ADDR_W, 8, width of branch target / PC.
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch (younger-stage squash depth); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flag_in  input  4  ALU flags {OddParity, Positive, Cout, Zero}, bits [3:0].
- flag_we  input  1  execute stage commits flag_in this cycle.
- flag_pending  input  1  an older flag-writing op is still in flight; branch must stall.
- save_req  input  1  copy effective flags to shadow register (interrupt entry).
- restore_req  input  1  load flag register from shadow (interrupt return).
- br_valid  input  1  branch request present.
- br_ready  output  1  unit accepts a branch this cycle.
- br_cc  input  4  condition code.
- br_target  input  ADDR_W  branch destination.
- cin_out  output  1  registered carry flag to the ALU carry input.
- flags_out  output  4  registered flag register.
- res_valid  output  1  one-cycle pulse: a branch was resolved.
- res_taken  output  1  resolution result; qualified by res_valid.
- illegal_cc  output  1  one-cycle pulse with res_valid when br_cc is reserved.
- pc_load  output  1  one-cycle pulse: load pc_target.
- pc_target  output  ADDR_W  registered target; qualified by pc_load.
- flush  output  1  squash younger stages.

Behaviour:
- Reset values (async, immediate on rst_n low):
  - flags register = 4'b0101 (P=0, S=1, C=0, Z=1, matching a zero ALU result).
  - shadow = 4'b0101.
  - All pulse outputs 0, flush 0, pc_target 0, state IDLE.
  - br_ready = 0 while rst_n is low.
- Effective flags (eff), combinational priority:
  - restore_req → shadow;
  - else flag_we → flag_in;
  - else flag register.
- Flag register update: the register loads eff every clock.
- Shadow update: on save_req the shadow loads eff. If save_req and restore_req are both asserted, the shadow is unchanged and the register is restored.
- cin_out = flags[1] taken from the register only. It is never bypassed from flag_in, to avoid a combinational loop through the ALU.
- Condition codes, evaluated on eff:
  - 0 ALWAYS; 1 Z; 2 NZ; 3 C; 4 NC; 5 POS (S=1); 6 NEG (S=0); 7 PO (P=1); 8 PE (P=0).
  - 9–15 reserved: not taken, and illegal_cc pulses.
- br_ready = (state==IDLE) && !flag_pending && rst_n.
- Accept occurs when br_valid && br_ready, in cycle N.
- FSM states IDLE, FLUSH:
  - IDLE, accept:
    - At N+1: res_valid=1, res_taken=cond, illegal_cc as applicable.
    - If taken: pc_load=1, pc_target=br_target, flush=1, state→FLUSH with counter=FLUSH_CYCLES-1.
    - If not taken: stay IDLE, and br_ready may be high at N+1.
  - FLUSH:
    - flush=1 and br_ready=0.
    - Counter decrements each cycle; at 0 → IDLE, with flush deasserted the following cycle.
    - flush is therefore high for exactly FLUSH_CYCLES cycles, N+1..N+FLUSH_CYCLES.
- Latency: branch resolution is 1 cycle after accept.
- br_valid while br_ready=0 is held by the requester; it is not an error.
- flag_we during FLUSH still updates flags (the older op commits).
- Reset mid-FLUSH aborts immediately: flush, pc_load and res_valid all drop asynchronously.

Decomposition:
- Shared package rnbip_pkg holds:
  - Flag bit indices FLG_Z=0, FLG_C=1, FLG_S=2, FLG_P=3.
  - Condition-code localparams CC_ALWAYS..CC_PE.
  - FLAG_RESET=4'b0101.
  - FSM state encoding.
- Sub-module flag_cond_eval: purely combinational. Takes (flags[3:0], cc[3:0]) and returns (taken, illegal).

Test Plan:
- Reset then idle: release rst_n, hold all inputs 0 → flags_out=4'b0101, cin_out=0, br_ready=1, flush=0.
- Bypass branch: flag_we=1, flag_in=4'b0001 (Z=1), br_valid=1, br_cc=1, br_target=8'h3C in the same cycle → next cycle res_valid=1, res_taken=1, pc_load=1, pc_target=8'h3C. flush is high for exactly 2 cycles and br_ready is low for those 2 cycles.
- Not taken: flags=4'b0100, br_cc=3 (C) → res_valid=1, res_taken=0, pc_load=0, flush=0, br_ready=1 the next cycle.
- Interlock: flag_pending=1 with br_valid=1 for 3 cycles → br_ready=0 and no res_valid. Then drop flag_pending with flag_we=1, flag_in=4'b0010 and br_cc=3 → taken; cin_out=1 one cycle after the write.
- Save/restore: flags=4'b1010, pulse save_req; write flags 4'b0101; pulse restore_req → flags_out=4'b1010. save_req and restore_req together → shadow unchanged.
- Illegal cc and reset abort: br_cc=4'hB → res_valid=1, res_taken=0, illegal_cc=1. Then take an ALWAYS branch, assert rst_n=0 during FLUSH → flush=0 immediately and flags_out=4'b0101.

Source files
------------

// File: rtl/rnbip_pkg.sv
// Shared definitions for the branch/flag unit: flag bit positions,
// condition-code encodings, flag reset value and FSM state encoding.
package rnbip_pkg;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_S = 2;
  localparam int FLG_P = 3;

  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_Z      = 4'd1;
  localparam logic [3:0] CC_NZ     = 4'd2;
  localparam logic [3:0] CC_C      = 4'd3;
  localparam logic [3:0] CC_NC     = 4'd4;
  localparam logic [3:0] CC_POS    = 4'd5;
  localparam logic [3:0] CC_NEG    = 4'd6;
  localparam logic [3:0] CC_PO     = 4'd7;
  localparam logic [3:0] CC_PE     = 4'd8;

  // Flags of a zero ALU result: P=0, S=1, C=0, Z=1.
  localparam logic [3:0] FLAG_RESET = 4'b0101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluator: decides whether a condition code is
// satisfied by a flag vector and flags reserved codes.
module flag_cond_eval
  import rnbip_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cc,
  output logic       taken,
  output logic       illegal
);

  // Decode the condition code against the supplied flags.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cc)
      CC_ALWAYS: taken = 1'b1;
      CC_Z:      taken = flags[FLG_Z];
      CC_NZ:     taken = ~flags[FLG_Z];
      CC_C:      taken = flags[FLG_C];
      CC_NC:     taken = ~flags[FLG_C];
      CC_POS:    taken = flags[FLG_S];
      CC_NEG:    taken = ~flags[FLG_S];
      CC_PO:     taken = flags[FLG_P];
      CC_PE:     taken = ~flags[FLG_P];
      default: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Architectural flag register with interrupt shadow, and conditional branch
// resolution with same-cycle flag bypass, PC load and younger-stage flush.
module branch_flag_unit
  import rnbip_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        flag_in,
  input  logic              flag_we,
  input  logic              flag_pending,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cc,
  input  logic [ADDR_W-1:0] br_target,
  output logic              cin_out,
  output logic [3:0]        flags_out,
  output logic              res_valid,
  output logic              res_taken,
  output logic              illegal_cc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  logic [3:0]        flags_r;
  logic [3:0]        shadow_r;
  logic [3:0]        eff_s;
  logic              taken_s;
  logic              illegal_s;
  logic              accept_s;
  state_t            state_r;
  state_t            state_next_s;
  logic [2:0]        cnt_r;
  logic [2:0]        cnt_next_s;
  logic              res_valid_r;
  logic              res_taken_r;
  logic              illegal_r;
  logic              pc_load_r;
  logic [ADDR_W-1:0] pc_target_r;
  logic              flush_r;

  // Effective flags: restore beats a fresh ALU write, which beats the register.
  always_comb begin
    eff_s = flags_r;
    if (restore_req) begin
      eff_s = shadow_r;
    end else if (flag_we) begin
      eff_s = flag_in;
    end else begin
      eff_s = flags_r;
    end
  end

  flag_cond_eval u_cond (
    .flags   (eff_s),
    .cc      (br_cc),
    .taken   (taken_s),
    .illegal (illegal_s)
  );

  assign br_ready = (state_r == ST_IDLE) && !flag_pending && rst_n;
  assign accept_s = br_valid && br_ready;

  // Flag register and interrupt shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r  <= FLAG_RESET;
      shadow_r <= FLAG_RESET;
    end else begin
      flags_r <= eff_s;
      if (save_req && !restore_req) begin
        shadow_r <= eff_s;
      end
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic: a taken branch holds flush for FLUSH_CYCLES cycles.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && taken_s) begin
          state_next_s = ST_FLUSH;
          cnt_next_s   = FLUSH_LAST;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 3'd0;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == 3'd0) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 3'd0;
        end else begin
          state_next_s = ST_FLUSH;
          cnt_next_s   = cnt_r - 3'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 3'd0;
      end
    endcase
  end

  // Registered resolution pulses, PC redirect and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_taken_r <= 1'b0;
      illegal_r   <= 1'b0;
      pc_load_r   <= 1'b0;
      pc_target_r <= '0;
      flush_r     <= 1'b0;
    end else begin
      res_valid_r <= accept_s;
      res_taken_r <= accept_s && taken_s;
      illegal_r   <= accept_s && illegal_s;
      pc_load_r   <= accept_s && taken_s;
      flush_r     <= (state_next_s == ST_FLUSH);
      if (accept_s && taken_s) begin
        pc_target_r <= br_target;
      end
    end
  end

  // Carry goes back to the ALU from the register only, never from flag_in.
  assign cin_out    = flags_r[FLG_C];
  assign flags_out  = flags_r;
  assign res_valid  = res_valid_r;
  assign res_taken  = res_taken_r;
  assign illegal_cc = illegal_r;
  assign pc_load    = pc_load_r;
  assign pc_target  = pc_target_r;
  assign flush      = flush_r;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: vector table, random branches,
// and hand-written interlock, save/restore and reset-abort sequences.
module tb_branch_flag_unit;

  localparam int AW = 8;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    flag_in;
  logic          flag_we, flag_pending, save_req, restore_req, br_valid;
  logic          br_ready;
  logic [3:0]    br_cc;
  logic [AW-1:0] br_target;
  logic          cin_out;
  logic [3:0]    flags_out;
  logic          res_valid, res_taken, illegal_cc, pc_load;
  logic [AW-1:0] pc_target;
  logic          flush;

  typedef struct packed {
    logic          taken;
    logic          illegal;
    logic [AW-1:0] target;
  } exp_t;

  typedef struct {
    logic          we;
    logic [3:0]    fin;
    logic [3:0]    cc;
    logic [AW-1:0] tgt;
    logic          tk;
    logic          il;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[15];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  branch_flag_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we(flag_we),
    .flag_pending(flag_pending), .save_req(save_req), .restore_req(restore_req),
    .br_valid(br_valid), .br_ready(br_ready), .br_cc(br_cc), .br_target(br_target),
    .cin_out(cin_out), .flags_out(flags_out), .res_valid(res_valid),
    .res_taken(res_taken), .illegal_cc(illegal_cc), .pc_load(pc_load),
    .pc_target(pc_target), .flush(flush)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference condition evaluation: returns {taken, illegal}.
  function automatic logic [1:0] cond_model(input logic [3:0] f, input logic [3:0] cc);
    logic z, c, s, p;
    {p, s, c, z} = f;
    if (cc == 4'd0) return 2'b10;
    else if (cc == 4'd1) return {z, 1'b0};
    else if (cc == 4'd2) return {~z, 1'b0};
    else if (cc == 4'd3) return {c, 1'b0};
    else if (cc == 4'd4) return {~c, 1'b0};
    else if (cc == 4'd5) return {s, 1'b0};
    else if (cc == 4'd6) return {~s, 1'b0};
    else if (cc == 4'd7) return {p, 1'b0};
    else if (cc == 4'd8) return {~p, 1'b0};
    else return 2'b01;
  endfunction

  // Scoreboard: every resolution pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: res_valid=1 with no branch outstanding (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("res_taken", res_taken, e.taken);
          chk("illegal_cc", illegal_cc, e.illegal);
          chk("pc_load", pc_load, e.taken);
          if (e.taken) chk("pc_target", pc_target, e.target);
        end
      end else begin
        chk("pc_load_idle", pc_load, 1'b0);
        chk("illegal_idle", illegal_cc, 1'b0);
      end
    end
  end

  task automatic do_branch(input logic we, input logic [3:0] fin, input logic [3:0] cc,
                           input logic [AW-1:0] tgt, input logic tk, input logic il,
                           input int pend);
    for (int k = 0; k < pend; k++) begin
      flag_pending = 1'b1; flag_we = 1'b0; br_valid = 1'b1; br_cc = cc; br_target = tgt;
      #1;
      chk("ready_pending", br_ready, 1'b0);
      step();
      chk("resv_pending", res_valid, 1'b0);
    end
    flag_pending = 1'b0; flag_we = we; flag_in = fin;
    br_valid = 1'b1; br_cc = cc; br_target = tgt;
    #1;
    chk("ready_idle", br_ready, 1'b1);
    if (we) mflags = fin;
    sb_q.push_back('{tk, il, tgt});
    step();
    flag_we = 1'b0; br_valid = 1'b0;
    chk("res_valid", res_valid, 1'b1);
    chk("flags_out", flags_out, mflags);
    chk("cin_out", cin_out, mflags[1]);
    if (tk) begin
      for (int i = 0; i < FC; i++) begin
        chk("flush_hi", flush, 1'b1);
        chk("ready_flush", br_ready, 1'b0);
        step();
      end
    end
    chk("flush_lo", flush, 1'b0);
    chk("ready_after", br_ready, 1'b1);
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1; flag_in = f;
    step();
    flag_we = 1'b0;
    mflags = f;
  endtask

  initial begin
    logic [1:0]    r;
    logic [3:0]    f, cc;
    logic          we;
    logic [AW-1:0] t;

    vecs = '{
      '{1'b1, 4'b0001, 4'd1,  8'h3C, 1'b1, 1'b0},
      '{1'b1, 4'b0100, 4'd3,  8'h10, 1'b0, 1'b0},
      '{1'b1, 4'b0100, 4'd2,  8'h11, 1'b1, 1'b0},
      '{1'b1, 4'b0010, 4'd3,  8'h12, 1'b1, 1'b0},
      '{1'b1, 4'b0000, 4'd4,  8'h13, 1'b1, 1'b0},
      '{1'b1, 4'b0100, 4'd5,  8'h14, 1'b1, 1'b0},
      '{1'b1, 4'b0100, 4'd6,  8'h15, 1'b0, 1'b0},
      '{1'b1, 4'b1000, 4'd7,  8'h16, 1'b1, 1'b0},
      '{1'b1, 4'b1000, 4'd8,  8'h17, 1'b0, 1'b0},
      '{1'b1, 4'b0000, 4'd0,  8'h18, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 4'hB,  8'h19, 1'b0, 1'b1},
      '{1'b1, 4'b0001, 4'd2,  8'h1A, 1'b0, 1'b0},
      '{1'b0, 4'b1110, 4'd1,  8'h1B, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 4'hF,  8'h1C, 1'b0, 1'b1},
      '{1'b0, 4'b0000, 4'd4,  8'h1D, 1'b0, 1'b0}
    };

    rst_n = 1'b0; flag_in = 4'd0; flag_we = 1'b0; flag_pending = 1'b0;
    save_req = 1'b0; restore_req = 1'b0; br_valid = 1'b0; br_cc = 4'd0; br_target = '0;
    mflags = 4'b0101;
    step(); step();
    chk("rst_ready", br_ready, 1'b0);
    chk("rst_flags", flags_out, 4'b0101);
    chk("rst_flush", flush, 1'b0);
    chk("rst_resv", res_valid, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_flags", flags_out, 4'b0101);
    chk("idle_cin", cin_out, 1'b0);
    chk("idle_ready", br_ready, 1'b1);
    chk("idle_flush", flush, 1'b0);

    foreach (vecs[i])
      do_branch(vecs[i].we, vecs[i].fin, vecs[i].cc, vecs[i].tgt, vecs[i].tk, vecs[i].il, 0);

    // Interlock: held off by flag_pending, then taken on the bypassed carry.
    do_branch(1'b1, 4'b0010, 4'd3, 8'h5A, 1'b1, 1'b0, 3);

    for (int n = 0; n < 20; n++) begin
      we = 1'($urandom_range(0, 1));
      f  = 4'($urandom_range(0, 15));
      cc = 4'($urandom_range(0, 15));
      t  = 8'($urandom_range(0, 255));
      r  = cond_model(we ? f : mflags, cc);
      do_branch(we, f, cc, t, r[1], r[0], n % 3);
    end

    // Save/restore through the shadow register.
    set_flags(4'b1010);
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    chk("save_flags", flags_out, 4'b1010);
    set_flags(4'b0101);
    chk("pre_restore", flags_out, 4'b0101);
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("restore", flags_out, 4'b1010);
    save_req = 1'b1; restore_req = 1'b1; flag_we = 1'b1; flag_in = 4'b0011;
    step();
    save_req = 1'b0; restore_req = 1'b0; flag_we = 1'b0;
    chk("both_restore", flags_out, 4'b1010);
    set_flags(4'b0110);
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("shadow_kept", flags_out, 4'b1010);
    mflags = 4'b1010;

    // Reset in the middle of a flush aborts everything at once.
    flag_we = 1'b1; flag_in = 4'b1010; br_valid = 1'b1; br_cc = 4'd0; br_target = 8'h77;
    #1;
    chk("abort_ready", br_ready, 1'b1);
    sb_q.push_back('{1'b1, 1'b0, 8'h77});
    step();
    flag_we = 1'b0; br_valid = 1'b0;
    #2;
    chk("abort_flush_pre", flush, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_flush", flush, 1'b0);
    chk("abort_pcload", pc_load, 1'b0);
    chk("abort_resv", res_valid, 1'b0);
    chk("abort_flags", flags_out, 4'b0101);
    chk("abort_ready0", br_ready, 1'b0);
    step(); step();
    rst_n = 1'b1;
    mflags = 4'b0101;
    step();
    chk("post_rst_flags", flags_out, 4'b0101);
    chk("post_rst_flush", flush, 1'b0);
    do_branch(1'b0, 4'b0000, 4'd1, 8'hA5, 1'b1, 1'b0, 0);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
